// File: rtl/syn_update_ctrl.sv
// Synaptic row update / readback controller: sweeps one pre-neuron row of the
// synapse SRAM word by word (read, wait, write-back) and serves single-word readbacks.
module syn_update_ctrl #(
  parameter int unsigned PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
  parameter int unsigned POST_NEUR_PARALLEL   = 4,
  parameter int unsigned OUTPUT_NEURON        = 256,
  parameter int unsigned SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int unsigned SYN_ARRAY_DATA_WIDTH = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            IS_TRAIN,
  input  logic                            UPD_START,
  input  logic [PRE_NEUR_ADDR_WIDTH-1:0]  UPD_PRE_ADDR,
  input  logic                            RD_REQ,
  input  logic [SYN_ARRAY_ADDR_WIDTH-1:0] RD_ADDR,
  input  logic [SYN_ARRAY_DATA_WIDTH-1:0] SYNARRAY_RDATA,
  output logic                            CTRL_SYNARRAY_CS,
  output logic                            CTRL_SYNARRAY_WE,
  output logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR,
  output logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
  output logic                            CTRL_TREF_EVENT,
  output logic                            BUSY,
  output logic                            UPD_DONE,
  output logic                            RD_VALID,
  output logic [SYN_ARRAY_DATA_WIDTH-1:0] RD_DATA
);

  localparam int unsigned WORDS   = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int unsigned WORD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PAR_LOG = $clog2(POST_NEUR_PARALLEL);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UPD_RD   = 3'd1,
    UPD_WAIT = 3'd2,
    UPD_WR   = 3'd3,
    UPD_FIN  = 3'd4,
    RB_RD    = 3'd5,
    RB_CAP   = 3'd6
  } state_t;

  state_t                            state, state_nxt;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]    row, row_nxt;
  logic [WORD_W-1:0]                 w, w_nxt;
  logic                              train, train_nxt;
  logic                              pend, pend_nxt;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]   pend_addr, pend_addr_nxt;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]   rb_addr, rb_addr_nxt;
  logic [SYN_ARRAY_DATA_WIDTH-1:0]   rd_data_q, rd_data_nxt;

  logic                              cs_nxt, we_nxt, tref_nxt, busy_nxt, done_nxt, rd_valid_nxt;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0]   addr_nxt;
  logic [POST_NEUR_ADDR_WIDTH-1:0]   post_nxt;

  // Capture cycle forwards the SRAM word so data and valid line up; afterwards the held copy is shown.
  assign RD_DATA = (state == RB_CAP) ? SYNARRAY_RDATA : rd_data_q;

  // State register; outputs are registered from the decode of the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state                    <= IDLE;
      row                      <= '0;
      w                        <= '0;
      train                    <= 1'b0;
      pend                     <= 1'b0;
      pend_addr                <= '0;
      rb_addr                  <= '0;
      rd_data_q                <= '0;
      CTRL_SYNARRAY_CS         <= 1'b0;
      CTRL_SYNARRAY_WE         <= 1'b0;
      CTRL_SYNARRAY_ADDR       <= '0;
      CTRL_POST_NEURON_ADDRESS <= '0;
      CTRL_TREF_EVENT          <= 1'b0;
      BUSY                     <= 1'b0;
      UPD_DONE                 <= 1'b0;
      RD_VALID                 <= 1'b0;
    end else begin
      state                    <= state_nxt;
      row                      <= row_nxt;
      w                        <= w_nxt;
      train                    <= train_nxt;
      pend                     <= pend_nxt;
      pend_addr                <= pend_addr_nxt;
      rb_addr                  <= rb_addr_nxt;
      rd_data_q                <= rd_data_nxt;
      CTRL_SYNARRAY_CS         <= cs_nxt;
      CTRL_SYNARRAY_WE         <= we_nxt;
      CTRL_SYNARRAY_ADDR       <= addr_nxt;
      CTRL_POST_NEURON_ADDRESS <= post_nxt;
      CTRL_TREF_EVENT          <= tref_nxt;
      BUSY                     <= busy_nxt;
      UPD_DONE                 <= done_nxt;
      RD_VALID                 <= rd_valid_nxt;
    end
  end

  // Next-state, sweep counters, pending readback and output decode.
  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    w_nxt         = w;
    train_nxt     = train;
    pend_nxt      = pend;
    pend_addr_nxt = pend_addr;
    rb_addr_nxt   = rb_addr;
    rd_data_nxt   = rd_data_q;
    cs_nxt        = 1'b0;
    we_nxt        = 1'b0;
    tref_nxt      = 1'b0;
    done_nxt      = 1'b0;
    rd_valid_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    addr_nxt      = CTRL_SYNARRAY_ADDR;
    post_nxt      = CTRL_POST_NEURON_ADDRESS;

    case (state)
      IDLE: begin
        if (UPD_START) begin
          row_nxt   = UPD_PRE_ADDR;
          w_nxt     = '0;
          train_nxt = IS_TRAIN;
          state_nxt = UPD_RD;
          if (RD_REQ) begin
            pend_nxt      = 1'b1;
            pend_addr_nxt = RD_ADDR;
          end
        end else if (RD_REQ) begin
          rb_addr_nxt = RD_ADDR;
          pend_nxt    = 1'b0;
          state_nxt   = RB_RD;
        end else if (pend) begin
          rb_addr_nxt = pend_addr;
          pend_nxt    = 1'b0;
          state_nxt   = RB_RD;
        end
      end
      UPD_RD:   state_nxt = UPD_WAIT;
      UPD_WAIT: state_nxt = UPD_WR;
      UPD_WR: begin
        if (w == LAST_WORD) begin
          state_nxt = UPD_FIN;
        end else begin
          w_nxt     = w + WORD_W'(1);
          state_nxt = UPD_RD;
        end
      end
      UPD_FIN:  state_nxt = IDLE;
      RB_RD:    state_nxt = RB_CAP;
      RB_CAP: begin
        rd_data_nxt = SYNARRAY_RDATA;
        state_nxt   = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase

    // Requests arriving while busy are parked; a newer one replaces the parked address.
    if (state != IDLE && RD_REQ) begin
      pend_nxt      = 1'b1;
      pend_addr_nxt = RD_ADDR;
    end

    busy_nxt     = (state_nxt != IDLE);
    rd_valid_nxt = (state_nxt == RB_CAP);

    case (state_nxt)
      UPD_RD, UPD_WAIT, UPD_WR: begin
        addr_nxt = SYN_ARRAY_ADDR_WIDTH'({row_nxt, w_nxt});
        post_nxt = POST_NEUR_ADDR_WIDTH'(w_nxt) << PAR_LOG;
        if (state_nxt == UPD_RD) begin
          cs_nxt = 1'b1;
        end else if (state_nxt == UPD_WR) begin
          cs_nxt   = train_nxt;
          we_nxt   = train_nxt;
          tref_nxt = 1'b1;
        end
      end
      UPD_FIN: done_nxt = 1'b1;
      RB_RD: begin
        cs_nxt   = 1'b1;
        addr_nxt = rb_addr_nxt;
      end
      default: ;
    endcase
  end

endmodule
